// File: rtl/qarb_pkg.sv
// Shared types for the queue access arbiter: requester opcodes, controller
// states and the opcode field width.
package qarb_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_TOP = 2'b00,
        OP_ENQ = 2'b01,
        OP_DEQ = 2'b10,
        OP_POP = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } state_t;

    // TOP and POP both read the head and therefore need a response cycle.
    function automatic logic op_is_read(op_t op);
        return (op == OP_TOP) || (op == OP_POP);
    endfunction

    // ENQ needs a free slot; every other opcode needs at least one entry.
    function automatic logic op_is_legal(op_t op, logic full, logic empty);
        return (op == OP_ENQ) ? !full : !empty;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational requester picker: round-robin starting after ptr, or fixed
// lowest-index priority when QARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDW-1:0]     winner_idx,
    output logic               any
);

`ifdef QARB_FIXED_PRIO_EN
    logic [IDW-1:0] ptr_unused;
    assign ptr_unused = ptr;

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        winner_idx = '0;
        any        = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner_idx = IDW'(i);
                any        = 1'b1;
            end
        end
    end
`else
    // Scan offsets from farthest to nearest so the nearest requester after
    // the last winner overrides everything behind it.
    always_comb begin
        int idx;
        winner_idx = '0;
        any        = 1'b0;
        idx        = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                winner_idx = IDW'(idx);
                any        = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        winner = '0;
        if (any) begin
            winner[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/queue_access_arbiter.sv
// Shares one single-command queue between NUM_REQ requesters, sequencing the
// two-step POP. Define QARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module queue_access_arbiter
    import qarb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int BITWIDTH = 8,
    parameter int IDW      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*OP_W-1:0]      req_op,
    input  logic [NUM_REQ*BITWIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         gnt_err,
    output logic                         rsp_valid,
    output logic [IDW-1:0]               rsp_id,
    output logic [BITWIDTH-1:0]          rsp_data,
    output logic                         busy,
    output logic                         q_enable,
    output logic                         q_enqueue,
    output logic                         q_dequeue,
    output logic                         q_top,
    output logic [BITWIDTH-1:0]          q_data_in,
    input  logic [BITWIDTH-1:0]          q_data_out,
    input  logic                         q_full,
    input  logic                         q_empty
);

    state_t                state_q;
    state_t                state_d;
    logic [IDW-1:0]        id_q;
    op_t                   op_q;
    logic [BITWIDTH-1:0]   data_q;
    logic [IDW-1:0]        ptr_q;

    logic [NUM_REQ-1:0]    win_onehot;
    logic [IDW-1:0]        win_idx;
    logic                  win_any;
    logic                  legal;

    logic [OP_W-1:0]       op_vec   [NUM_REQ];
    logic [BITWIDTH-1:0]   data_vec [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_vec[i]   = req_op[i*OP_W +: OP_W];
        assign data_vec[i] = req_data[i*BITWIDTH +: BITWIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req        (req),
        .ptr        (ptr_q),
        .winner     (win_onehot),
        .winner_idx (win_idx),
        .any        (win_any)
    );

    logic [NUM_REQ-1:0] win_onehot_unused;
    assign win_onehot_unused = win_onehot;

    // The winner's fields are captured on leaving IDLE so the requester may
    // drop its request as soon as it sees the grant. The pointer moves on
    // every grant, rejected ones included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            op_q    <= OP_TOP;
            data_q  <= '0;
            ptr_q   <= IDW'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && win_any) begin
                id_q   <= win_idx;
                op_q   <= op_t'(op_vec[win_idx]);
                data_q <= data_vec[win_idx];
            end
            if (state_q == ST_ISSUE) begin
                ptr_q <= id_q;
            end
        end
    end

    assign legal = op_is_legal(op_q, q_full, q_empty);
    assign busy  = (state_q != ST_IDLE);

    // Legality is judged only in ISSUE; the queue cannot change between
    // ISSUE and RESP, so the POP dequeue in RESP needs no second check.
    always_comb begin
        state_d   = state_q;
        gnt       = '0;
        gnt_err   = 1'b0;
        rsp_valid = 1'b0;
        rsp_id    = '0;
        rsp_data  = '0;
        q_enable  = 1'b0;
        q_enqueue = 1'b0;
        q_dequeue = 1'b0;
        q_top     = 1'b0;
        q_data_in = '0;

        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                gnt[id_q] = 1'b1;
                gnt_err   = !legal;
                if (legal) begin
                    q_enable = 1'b1;
                    case (op_q)
                        OP_ENQ: begin
                            q_enqueue = 1'b1;
                            q_data_in = data_q;
                        end
                        OP_DEQ:  q_dequeue = 1'b1;
                        default: q_top     = 1'b1;
                    endcase
                end
                state_d = (legal && op_is_read(op_q)) ? ST_RESP : ST_IDLE;
            end

            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = id_q;
                rsp_data  = q_data_out;
                if (op_q == OP_POP) begin
                    q_enable  = 1'b1;
                    q_dequeue = 1'b1;
                end
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_queue_access_arbiter.sv
// Randomized scoreboard bench for queue_access_arbiter with a behavioural queue
// in front of it and a transaction-level reference model of the arbitration rules.
module tb_queue_access_arbiter;
    import qarb_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int BITWIDTH = 8;
    localparam int IDW      = 2;
    localparam int QSIZE    = 4;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [NUM_REQ-1:0]          req = '0;
    logic [NUM_REQ*2-1:0]        req_op = '0;
    logic [NUM_REQ*BITWIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]          gnt;
    logic                        gnt_err;
    logic                        rsp_valid;
    logic [IDW-1:0]              rsp_id;
    logic [BITWIDTH-1:0]         rsp_data;
    logic                        busy;
    logic                        q_enable, q_enqueue, q_dequeue, q_top;
    logic [BITWIDTH-1:0]         q_data_in;
    logic [BITWIDTH-1:0]         q_data_out = '0;
    logic                        q_full = 1'b0;
    logic                        q_empty = 1'b1;

    queue_access_arbiter #(.NUM_REQ(NUM_REQ), .BITWIDTH(BITWIDTH), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_data(req_data),
        .gnt(gnt), .gnt_err(gnt_err), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy), .q_enable(q_enable), .q_enqueue(q_enqueue),
        .q_dequeue(q_dequeue), .q_top(q_top), .q_data_in(q_data_in),
        .q_data_out(q_data_out), .q_full(q_full), .q_empty(q_empty)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural queue driven only by the DUT's commands; not reset by rst.
    logic [BITWIDTH-1:0] envq[$];
    always @(posedge clk) begin
        if (q_enable) begin
            if (q_top && envq.size() > 0) q_data_out <= envq[0];
            if (q_enqueue && envq.size() < QSIZE) envq.push_back(q_data_in);
            if (q_dequeue && envq.size() > 0) void'(envq.pop_front());
        end
        q_full  <= (envq.size() == QSIZE);
        q_empty <= (envq.size() == 0);
    end

    typedef struct {
        int                 cyc;
        logic [NUM_REQ-1:0] gnt;
        logic               err;
        logic [3:0]         cmd;
        logic [BITWIDTH-1:0] din;
    } gnt_exp_t;

    typedef struct {
        int                  cyc;
        logic [IDW-1:0]      id;
        logic [BITWIDTH-1:0] data;
        logic                pop;
    } rsp_exp_t;

    gnt_exp_t gq[$];
    rsp_exp_t rq[$];

    int vectors = 0;
    int errors  = 0;

    // Reference model state: pending requests, model queue contents, last winner.
    logic                pending  [NUM_REQ];
    op_t                 pend_op  [NUM_REQ];
    logic [BITWIDTH-1:0] pend_data[NUM_REQ];
    int                  gnt_cyc  [NUM_REQ];
    logic [BITWIDTH-1:0] ref_q[$];
    int                  last_winner = NUM_REQ - 1;
    int                  next_arb = 0;
    bit                  rand_en = 1'b0;
    int                  last_rsp_cyc = -1;
    logic [BITWIDTH-1:0] last_rsp_data = '0;

    task automatic compare(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pickWinner(logic [NUM_REQ-1:0] r, int last);
`ifdef QARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++) if (r[i]) return i + 0 * last;
`else
        for (int k = 1; k <= NUM_REQ; k++) if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
`endif
        return -1;
    endfunction

    function automatic op_t randomOp();
        int r = int'($urandom_range(0, 99));
        if (r < 40) return OP_ENQ;
        if (r < 55) return OP_TOP;
        if (r < 75) return OP_DEQ;
        return OP_POP;
    endfunction

    // One step per falling edge: retire granted requesters, raise new ones,
    // arbitrate in the model whenever the controller is due back in IDLE,
    // then drive the request wires for the coming rising edge.
    task automatic applyStimulus();
        logic [NUM_REQ-1:0] just_dropped;
        logic [NUM_REQ-1:0] rv;
        just_dropped = '0;
        rv = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pending[i] && gnt_cyc[i] == cyc) begin
                pending[i] = 1'b0;
                just_dropped[i] = 1'b1;
            end
        end
        if (rand_en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pending[i] && !just_dropped[i] && $urandom_range(0, 2) == 0) begin
                    pending[i]   = 1'b1;
                    pend_op[i]   = randomOp();
                    pend_data[i] = BITWIDTH'($urandom);
                    gnt_cyc[i]   = -1;
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) rv[i] = pending[i] && gnt_cyc[i] < 0;
        if (cyc >= next_arb && rv != '0) begin
            int w;
            op_t op;
            bit legal;
            bit rd;
            gnt_exp_t g;
            w  = pickWinner(rv, last_winner);
            op = pend_op[w];
            legal = (op == OP_ENQ) ? (ref_q.size() < QSIZE) : (ref_q.size() > 0);
            rd = legal && (op == OP_TOP || op == OP_POP);
            g.cyc = cyc + 1;
            g.gnt = '0;
            g.gnt[w] = 1'b1;
            g.err = !legal;
            g.cmd = {legal, legal && op == OP_ENQ, legal && op == OP_DEQ, rd};
            g.din = (legal && op == OP_ENQ) ? pend_data[w] : '0;
            gq.push_back(g);
            if (rd) begin
                rsp_exp_t r;
                r.cyc  = cyc + 2;
                r.id   = IDW'(w);
                r.data = ref_q[0];
                r.pop  = (op == OP_POP);
                rq.push_back(r);
                last_rsp_cyc  = cyc + 2;
                last_rsp_data = ref_q[0];
            end
            if (legal && op == OP_ENQ) ref_q.push_back(pend_data[w]);
            if (legal && (op == OP_DEQ || op == OP_POP)) void'(ref_q.pop_front());
            gnt_cyc[w]  = cyc + 1;
            last_winner = w;
            next_arb    = rd ? cyc + 3 : cyc + 2;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i]                      = pending[i];
            req_op[i*2 +: 2]            = pending[i] ? pend_op[i] : OP_TOP;
            req_data[i*BITWIDTH +: BITWIDTH] = pending[i] ? pend_data[i] : '0;
        end
    endtask

    // Monitor: expectations carry the cycle they are due in; anything the DUT
    // shows outside a due cycle must be quiet.
    task automatic checkOutput();
        bit gdue;
        bit rdue;
        gdue = gq.size() > 0 && gq[0].cyc == cyc;
        rdue = rq.size() > 0 && rq[0].cyc == cyc;
        if (gdue) begin
            gnt_exp_t g = gq.pop_front();
            compare("gnt", 32'(gnt), 32'(g.gnt));
            compare("gnt_err", 32'(gnt_err), 32'(g.err));
            compare("issue_cmd", 32'({q_enable, q_enqueue, q_dequeue, q_top}), 32'(g.cmd));
            compare("issue_din", 32'(q_data_in), 32'(g.din));
            compare("issue_busy", 32'(busy), 32'd1);
        end else begin
            compare("gnt_quiet", 32'({gnt, gnt_err}), 32'd0);
        end
        if (rdue) begin
            rsp_exp_t r = rq.pop_front();
            compare("rsp_valid", 32'(rsp_valid), 32'd1);
            compare("rsp_id", 32'(rsp_id), 32'(r.id));
            compare("rsp_data", 32'(rsp_data), 32'(r.data));
            compare("resp_cmd", 32'({q_enable, q_enqueue, q_dequeue, q_top}), 32'({r.pop, 1'b0, r.pop, 1'b0}));
        end else begin
            compare("rsp_quiet", 32'({rsp_valid, rsp_id, rsp_data}), 32'd0);
        end
        if (!gdue && !rdue) begin
            compare("idle_quiet", 32'({busy, q_enable, q_enqueue, q_dequeue, q_top, q_data_in}), 32'd0);
        end
    endtask

    always @(negedge clk) if (rst) checkOutput();

    function automatic logic [31:0] allOutputs();
        return 32'({gnt, gnt_err, rsp_valid, rsp_id, rsp_data, busy,
                    q_enable, q_enqueue, q_dequeue, q_top, q_data_in});
    endfunction

    task automatic drain(string name);
        int budget = 300;
        rand_en = 1'b0;
        while (budget > 0) begin
            bit any_pend = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) any_pend |= pending[i];
            if (!any_pend && cyc >= next_arb && gq.size() == 0 && rq.size() == 0) break;
            @(negedge clk);
            applyStimulus();
            budget--;
        end
        compare({name, "_drain_timeout"}, 32'(budget > 0), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pending[i] = 1'b0; pend_op[i] = OP_TOP; pend_data[i] = '0; gnt_cyc[i] = -1;
        end
        #1 rst = 1'b0;
        // Reset state: everything quiet while rst is held low.
        repeat (3) begin
            @(negedge clk);
            compare("reset_outputs", allOutputs(), 32'd0);
        end
        rst = 1'b1;
        next_arb = cyc;
        last_winner = NUM_REQ - 1;

        rand_en = 1'b1;
        repeat (2000) begin
            @(negedge clk);
            applyStimulus();
        end
        drain("random");

        // Abort a POP in its response cycle with an asynchronous reset.
        if (ref_q.size() == 0) begin
            pending[0] = 1'b1; pend_op[0] = OP_ENQ; pend_data[0] = 8'hA5; gnt_cyc[0] = -1;
            drain("preload");
        end
        pending[1] = 1'b1; pend_op[1] = OP_POP; pend_data[1] = '0; gnt_cyc[1] = -1;
        last_rsp_cyc = -1;
        begin
            int budget = 20;
            while (budget > 0) begin
                @(negedge clk);
                applyStimulus();
                if (last_rsp_cyc == cyc) break;
                budget--;
            end
            compare("pop_reached_resp", 32'(budget > 0), 32'd1);
        end
        #1 rst = 1'b0;
        #1 compare("reset_in_resp", allOutputs(), 32'd0);
        ref_q.push_front(last_rsp_data);
        @(posedge clk);
        #1;
        compare("pop_abort_count", 32'(envq.size()), 32'(ref_q.size()));
        if (envq.size() > 0 && ref_q.size() > 0)
            compare("pop_abort_head", 32'(envq[0]), 32'(ref_q[0]));
        @(negedge clk);
        rst = 1'b1;
        last_winner = NUM_REQ - 1;
        next_arb = cyc;

        rand_en = 1'b1;
        repeat (400) begin
            @(negedge clk);
            applyStimulus();
        end
        drain("final");

        compare("final_count", 32'(envq.size()), 32'(ref_q.size()));
        for (int i = 0; i < QSIZE; i++) begin
            if (i < envq.size() && i < ref_q.size())
                compare("final_entry", 32'(envq[i]), 32'(ref_q[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/queue_access_arbiter.md
# queue_access_arbiter

Controller that shares one NxMQueue instance between NUM_REQ requesters. It arbitrates between them round-robin and issues exactly one legal single-operation command per grant on the queue's enable/enqueue/dequeue/top inputs. It also sequences the atomic POP (top then dequeue) that the queue cannot do in one command, and returns read data with the requester ID. It sits directly in front of the queue; requesters never drive it.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- BITWIDTH, 8, data width; matches queue BITWIDTH
- IDW, derived, $clog2(NUM_REQ), requester ID width

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester request, level
- req_op  in  NUM_REQ×2  per-requester opcode: 00 TOP (peek), 01 ENQ, 10 DEQ (discard), 11 POP (peek+discard)
- req_data  in  NUM_REQ×BITWIDTH  per-requester enqueue data
- gnt  out  NUM_REQ  one-hot grant pulse, one cycle
- gnt_err  out  1  qualifies gnt: op rejected (ENQ when full; TOP/DEQ/POP when empty)
- rsp_valid  out  1  read response pulse
- rsp_id  out  IDW  requester that owns rsp_data
- rsp_data  out  BITWIDTH  peeked head entry
- busy  out  1  state ≠ IDLE
- q_enable, q_enqueue, q_dequeue, q_top  out  1 each  queue command
- q_data_in  out  BITWIDTH  queue write data
- q_data_out  in  BITWIDTH  queue registered read data
- q_full, q_empty  in  1 each  queue overflow/empty flags

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any req, pick winner, latch id/op/data, go to ISSUE. Otherwise stay.
- ISSUE: compute legality from q_full/q_empty. Pulse gnt[id]; gnt_err = !legal. If legal, assert q_enable plus exactly one of q_enqueue (ENQ), q_dequeue (DEQ), q_top (TOP/POP). Go to RESP if legal TOP/POP, else to IDLE.
- RESP: rsp_valid=1, rsp_id=latched id, rsp_data=q_data_out. For POP also assert q_enable+q_dequeue. Go to IDLE.
- Never assert two q_* op bits together. All q_* are 0 outside ISSUE/RESP.
- Round-robin: pointer holds last winner. Search starts at pointer+1 mod NUM_REQ. Pointer updates on every grant, including err grants. Reset value NUM_REQ-1, so req[0] wins first.
- Requester holds req/op/data stable until gnt and deasserts req the cycle after gnt. A req dropped before gnt is a protocol violation (unsupported).

## Timing
- Reset (rst=0, async): state IDLE, pointer NUM_REQ-1. Every output is 0 immediately, including all q_*. rsp_id=0, rsp_data mirrors q_data_out only in RESP (else 0).
- Reset mid-operation aborts the op: no gnt, no rsp, no queue command. A POP reset between ISSUE and RESP leaves the entry in the queue.
- ENQ/DEQ and rejected ops take 2 cycles (IDLE, ISSUE). TOP/POP take 3 cycles; rsp_valid comes 1 cycle after gnt.
- gnt/gnt_err/q_* are decoded from state, latched fields and the current q_full/q_empty.
- Queue flags are stable in ISSUE because the previous command committed at least 1 edge earlier. POP legality is checked once, in ISSUE. The count cannot change before RESP.
- Max throughput: one op per 2 cycles.

## Configuration
- QARB_FIXED_PRIO_EN: defined → fixed priority, lowest index wins, pointer unused. Undefined → round-robin as above.

## Structure
- Package qarb_pkg: op_t enum (OP_TOP, OP_ENQ, OP_DEQ, OP_POP), state_t enum, opcode width constant.
- Sub-module rr_arbiter (req vector + pointer → one-hot winner + index). It also handles fixed-priority mode under the macro.

## Test plan
- Reset, req[2]=ENQ 0x5A, queue empty → cycle 1 gnt=0100, gnt_err=0, q_enable=q_enqueue=1, q_data_in=0x5A.
- Queue holds 0x11,0x22 (0x11 oldest); req[1]=POP → gnt[1], q_top; next cycle rsp_valid, rsp_id=1, rsp_data=0x11, q_dequeue=1; queue then holds only 0x22.
- req=1111 all ENQ continuously → grant order 0,1,2,3,0 (with macro: 0,0,0…).
- Queue empty, req[3]=DEQ → gnt[3], gnt_err=1, all q_*=0, no rsp_valid.
- Queue full (QUEUESIZE entries), req[0]=ENQ → gnt_err=1, q_enqueue=0, count unchanged.
- rst low during RESP of POP → all outputs 0 at once, no q_dequeue, entry retained.
